// File: rtl/shift_sequencer.sv
// Multicycle controller for the shift-register datapath (RegDesloc + ShiftAmt mux).
// Ports: clk, reset (async, active-low), req, op[2:0], shamt_in[4:0], regb_amt_in[4:0]
//        -> busy, done, err, ShiftAmtControl[1:0], ShiftSrc, Shift[2:0]
// Macro SHIFT_SERIAL_EN: repeat SHIFT for amt cycles, 1 bit per cycle (const-1 amount).
module shift_sequencer #(
   parameter int CNT_W = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req,
   input  logic [2:0] op,
   input  logic [4:0] shamt_in,
   input  logic [4:0] regb_amt_in,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [1:0] ShiftAmtControl,
   output logic       ShiftSrc,
   output logic [2:0] Shift
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state_q;
   state_t           state_d;

   logic             dec_src;
   logic             dec_ill;
   logic [1:0]       dec_sel;
   logic [2:0]       dec_dir;
   logic [4:0]       dec_amt;

   logic             src_q;
   logic             ill_q;
   logic [1:0]       sel_q;
   logic [2:0]       dir_q;
   logic [CNT_W-1:0] amt_q;

   logic             accept;

   logic             busy_d;
   logic             done_d;
   logic             err_d;
   logic             src_d;
   logic [1:0]       sel_d;
   logic [2:0]       shift_d;

`ifdef SHIFT_SERIAL_EN
   logic [CNT_W-1:0] cnt_q;
`endif

   // Illegal op loads RegA with the OFFSET amount select; err flags it.
   always_comb begin
      dec_src = 1'b1;
      dec_sel = 2'b00;
      dec_dir = 3'b000;
      dec_amt = shamt_in;
      dec_ill = 1'b0;
      case (op)
         3'b000: dec_dir = 3'b010;
         3'b001: dec_dir = 3'b011;
         3'b010: dec_dir = 3'b100;
         3'b011: begin
            dec_src = 1'b0;
            dec_sel = 2'b10;
            dec_dir = 3'b010;
            dec_amt = regb_amt_in;
         end
         3'b100: begin
            dec_src = 1'b0;
            dec_sel = 2'b10;
            dec_dir = 3'b011;
            dec_amt = regb_amt_in;
         end
         3'b101: begin
            dec_src = 1'b0;
            dec_sel = 2'b10;
            dec_dir = 3'b100;
            dec_amt = regb_amt_in;
         end
         3'b110: begin
            dec_sel = 2'b01;
            dec_dir = 3'b010;
            dec_amt = 5'd16;
         end
         default: begin
            dec_src = 1'b0;
            dec_ill = 1'b1;
         end
      endcase
   end

   assign accept = (state_q == IDLE) && req;

   // State, capture and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q         <= IDLE;
         src_q           <= 1'b0;
         ill_q           <= 1'b0;
         sel_q           <= 2'b00;
         dir_q           <= 3'b000;
         amt_q           <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         err             <= 1'b0;
         ShiftAmtControl <= 2'b00;
         ShiftSrc        <= 1'b0;
         Shift           <= 3'b000;
      end else begin
         state_q         <= state_d;
         busy            <= busy_d;
         done            <= done_d;
         err             <= err_d;
         ShiftAmtControl <= sel_d;
         ShiftSrc        <= src_d;
         Shift           <= shift_d;
         if (accept) begin
            src_q <= dec_src;
            ill_q <= dec_ill;
            sel_q <= dec_sel;
            dir_q <= dec_dir;
            amt_q <= CNT_W'(dec_amt);
         end
      end
   end

`ifdef SHIFT_SERIAL_EN
   // Holds amt through LOAD, then counts down once per SHIFT cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (accept) begin
         cnt_q <= CNT_W'(dec_amt);
      end else if (state_q == SHIFT) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (req) state_d = LOAD;
         LOAD: begin
            if (ill_q || (amt_q == '0)) state_d = DONE;
            else                        state_d = SHIFT;
         end
`ifdef SHIFT_SERIAL_EN
         SHIFT: if (cnt_q == CNT_W'(1)) state_d = DONE;
`else
         SHIFT: state_d = DONE;
`endif
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they appear registered
   // in the same cycle the state does. LOAD is only entered on accept,
   // so it uses the live decode rather than the captured copy.
   always_comb begin
      busy_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      src_d   = 1'b0;
      sel_d   = 2'b00;
      shift_d = 3'b000;
      case (state_d)
         LOAD: begin
            busy_d  = 1'b1;
            shift_d = 3'b001;
            src_d   = dec_src;
            sel_d   = dec_sel;
         end
         SHIFT: begin
            busy_d  = 1'b1;
            shift_d = dir_q;
            src_d   = src_q;
`ifdef SHIFT_SERIAL_EN
            sel_d   = 2'b11;
`else
            sel_d   = sel_q;
`endif
         end
         DONE: begin
            busy_d = 1'b1;
            done_d = 1'b1;
            err_d  = ill_q;
            src_d  = src_q;
            sel_d  = sel_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural RegDesloc model
// driven by the sequencer outputs, so final shift results are checked too.
module tb_shift_sequencer;

`ifdef SHIFT_SERIAL_EN
   localparam bit SERIAL = 1'b1;
`else
   localparam bit SERIAL = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        req;
   logic [2:0]  op;
   logic [4:0]  shamt_in;
   logic [4:0]  regb_amt_in;
   logic        busy;
   logic        done;
   logic        err;
   logic [1:0]  ShiftAmtControl;
   logic        ShiftSrc;
   logic [2:0]  Shift;

   logic [31:0] reg_a;
   logic [31:0] reg_b;
   logic [31:0] rd;
   logic [31:0] opnd;
   logic [4:0]  n;

   int checks = 0;
   int errors = 0;

   shift_sequencer dut (
      .clk             (clk),
      .reset           (reset),
      .req             (req),
      .op              (op),
      .shamt_in        (shamt_in),
      .regb_amt_in     (regb_amt_in),
      .busy            (busy),
      .done            (done),
      .err             (err),
      .ShiftAmtControl (ShiftAmtControl),
      .ShiftSrc        (ShiftSrc),
      .Shift           (Shift)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign regb_amt_in = reg_b[4:0];

   always_comb begin
      opnd = ShiftSrc ? reg_b : reg_a;
      case (ShiftAmtControl)
         2'b00:   n = shamt_in;
         2'b01:   n = 5'd16;
         2'b10:   n = regb_amt_in;
         default: n = 5'd1;
      endcase
   end

   always @(posedge clk) begin
      case (Shift)
         3'b001:  rd <= opnd;
         3'b010:  rd <= rd << n;
         3'b011:  rd <= rd >> n;
         3'b100:  rd <= $unsigned($signed(rd) >>> n);
         default: rd <= rd;
      endcase
   end

   function automatic logic [31:0] outs();
      return {23'd0, busy, done, err, ShiftAmtControl, ShiftSrc, Shift};
   endfunction

   function automatic logic [31:0] pk(input logic b, input logic d,
                                      input logic e, input logic [1:0] s,
                                      input logic src, input logic [2:0] sh);
      return {23'd0, b, d, e, s, src, sh};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one request from IDLE and check every cycle through the
   // return to IDLE; the number of SHIFT cycles fixes done latency.
   task automatic run_op(input string tag, input logic [2:0] o,
                         input logic [4:0] sh, input logic [31:0] a,
                         input logic [31:0] b, input logic e_src,
                         input logic [1:0] e_sel, input logic [2:0] e_dir,
                         input int e_amt, input logic e_ill,
                         input logic hold, input logic chk_res,
                         input logic [31:0] e_res);
      int ns;
      op       = o;
      shamt_in = sh;
      reg_a    = a;
      reg_b    = b;
      req      = 1'b1;
      @(negedge clk);
      if (!hold) begin
         req = 1'b0;
         op  = ~o;
      end
      chk({tag, "/load"}, outs(), pk(1, 0, 0, e_sel, e_src, 3'b001));
      if (e_ill || e_amt == 0) ns = 0;
      else if (SERIAL)         ns = e_amt;
      else                     ns = 1;
      for (int i = 0; i < ns; i++) begin
         @(negedge clk);
         chk({tag, "/shift"}, outs(),
             pk(1, 0, 0, SERIAL ? 2'b11 : e_sel, e_src, e_dir));
      end
      @(negedge clk);
      chk({tag, "/done"}, outs(), pk(1, 1, e_ill, e_sel, e_src, 3'b000));
      if (chk_res) chk({tag, "/result"}, rd, e_res);
      @(negedge clk);
      chk({tag, "/idle"}, outs(), 32'd0);
   endtask

   initial begin
      reset    = 1'b0;
      req      = 1'b1;
      op       = 3'b000;
      shamt_in = 5'd5;
      reg_a    = 32'd0;
      reg_b    = 32'h3;
      repeat (2) @(negedge clk);
      chk("rst", outs(), 32'd0);
      reset = 1'b1;
      #1;
      chk("release", outs(), 32'd0);

      run_op("sll5", 3'b000, 5'd5, 32'h0, 32'h3,
             1, 2'b00, 3'b010, 5, 0, 0, 1, 32'h0000_0060);
      run_op("srav4", 3'b101, 5'd0, 32'h8000_0000, 32'h4,
             0, 2'b10, 3'b100, 4, 0, 0, 1, 32'hF800_0000);
      run_op("lui", 3'b110, 5'd0, 32'h0, 32'h1234,
             1, 2'b01, 3'b010, 16, 0, 1, 1, 32'h1234_0000);
      run_op("lui2", 3'b110, 5'd0, 32'h0, 32'hABCD,
             1, 2'b01, 3'b010, 16, 0, 0, 1, 32'hABCD_0000);
      run_op("srl0", 3'b001, 5'd0, 32'h0, 32'h5A5A_0001,
             1, 2'b00, 3'b011, 0, 0, 0, 1, 32'h5A5A_0001);
      run_op("ill", 3'b111, 5'd3, 32'h1, 32'h2,
             0, 2'b00, 3'b000, 3, 1, 0, 0, 32'h0);
      run_op("sra3", 3'b010, 5'd3, 32'h0, 32'h8000_0010,
             1, 2'b00, 3'b100, 3, 0, 0, 1, 32'hF000_0002);
      run_op("sllv0", 3'b011, 5'd9, 32'h77, 32'h20,
             0, 2'b10, 3'b010, 0, 0, 0, 1, 32'h0000_0077);
      run_op("sll7", 3'b000, 5'd7, 32'h0, 32'h1,
             1, 2'b00, 3'b010, 7, 0, 0, 1, 32'h0000_0080);
      run_op("srlv31", 3'b100, 5'd0, 32'h8000_0000, 32'h1F,
             0, 2'b10, 3'b011, 31, 0, 0, 1, 32'h0000_0001);

      op       = 3'b000;
      shamt_in = 5'd2;
      reg_b    = 32'h1;
      req      = 1'b1;
      @(negedge clk);
      req = 1'b0;
      chk("abort/load", outs(), pk(1, 0, 0, 2'b00, 1, 3'b001));
      @(negedge clk);
      chk("abort/shift", outs(),
          pk(1, 0, 0, SERIAL ? 2'b11 : 2'b00, 1, 3'b010));
      #1 reset = 1'b0;
      #1;
      chk("abort/now", outs(), 32'd0);
      @(negedge clk);
      chk("abort/held", outs(), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("abort/idle", outs(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
